// File: rtl/chunk_serializer.sv
// chunk_serializer
//   Parallel-to-serial converter. A word of REG_WIDTH chunks, each CHUNK_WIDTH
//   bits wide, is captured on a valid/ready handshake and emitted one chunk
//   per beat on a valid/ready output stream. Words can follow each other with
//   no idle cycle because a new word loads on the edge that accepts the last
//   chunk of the current one.
//
//   Optional feature macro: CHUNK_SERIALIZER_MSB_FIRST_EN
//     defined   : chunk REG_WIDTH-1 is emitted first, chunk 0 last
//     undefined : chunk 0 is emitted first (matches shift_register capture)
//
// Ports
//   clk      in   clock, all state on posedge
//   rst_n    in   synchronous active-low reset
//   data_i   in   parallel word [REG_WIDTH-1:0][CHUNK_WIDTH-1:0]
//   valid_i  in   data_i valid
//   ready_o  out  a word can be accepted this cycle
//   data_o   out  current chunk (0 when idle)
//   valid_o  out  data_o valid
//   ready_i  in   downstream accepts data_o this cycle
//   last_o   out  current chunk is the final chunk of the word
module chunk_serializer #(
  parameter int CHUNK_WIDTH = 8,
  parameter int REG_WIDTH   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [REG_WIDTH-1:0][CHUNK_WIDTH-1:0] data_i,
  input  logic                                  valid_i,
  output logic                                  ready_o,
  output logic [CHUNK_WIDTH-1:0]                data_o,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic                                  last_o
);

  localparam int IDX_W = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                                state, state_n;
  logic [IDX_W-1:0]                      idx, idx_n;
  logic [REG_WIDTH-1:0][CHUNK_WIDTH-1:0] hold, hold_n;
  logic [IDX_W-1:0]                      sel;
  logic                                  beat;
  logic                                  load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      hold  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      hold  <= hold_n;
    end
  end

`ifdef CHUNK_SERIALIZER_MSB_FIRST_EN
  assign sel = LAST_IDX - idx;
`else
  assign sel = idx;
`endif

  always_comb begin
    valid_o = (state == SEND);
    last_o  = (state == SEND) && (idx == LAST_IDX);
    data_o  = (state == SEND) ? hold[sel] : '0;
    beat    = valid_o && ready_i;
    // Only combinational path from ready_i: the last beat frees the holding
    // register in the same cycle so the next word can load on that edge.
    ready_o = (state == IDLE) || (beat && last_o);
    load    = valid_i && ready_o;

    state_n = state;
    idx_n   = idx;
    hold_n  = hold;

    if (beat) begin
      if (idx != LAST_IDX) begin
        idx_n = idx + 1'b1;
      end else begin
        state_n = IDLE;
      end
    end

    // A load can only coincide with a final beat or an idle cycle, so it
    // simply overrides whatever the beat logic chose.
    if (load) begin
      hold_n  = data_i;
      idx_n   = '0;
      state_n = SEND;
    end
  end

endmodule

// File: tb/tb_chunk_serializer.sv
module tb_chunk_serializer;

  logic             clk;
  logic             rst_n;
  logic [3:0][7:0]  data_i;
  logic             valid_i;
  logic             ready_o;
  logic [7:0]       data_o;
  logic             valid_o;
  logic             ready_i;
  logic             last_o;

  int unsigned checks;
  int unsigned errors;
  logic [31:0] recv;

  chunk_serializer #(.CHUNK_WIDTH(8), .REG_WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .last_o  (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected k-th emitted chunk of a word.
  function automatic logic [7:0] exp_chunk(input logic [31:0] w, input int k);
`ifdef CHUNK_SERIALIZER_MSB_FIRST_EN
    exp_chunk = w[(3 - k) * 8 +: 8];
`else
    exp_chunk = w[k * 8 +: 8];
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({tag, "_data"},  {24'd0, data_o},  32'd0);
    chk({tag, "_last"},  {31'd0, last_o},  32'd0);
    chk({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] w, input int k,
                          input logic exp_ready);
    chk({tag, "_data"},  {24'd0, data_o},  {24'd0, exp_chunk(w, k)});
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    chk({tag, "_last"},  {31'd0, last_o},  {31'd0, (k == 3)});
    chk({tag, "_ready"}, {31'd0, ready_o}, {31'd0, exp_ready});
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    recv    = '0;
    rst_n   = 1'b0;
    valid_i = 1'b1;
    ready_i = 1'b1;
    data_i  = 32'hDDCCBBAA;

    // Reset with valid_i asserted must not load anything.
    step();
    valid_i = 1'b0;
    rst_n   = 1'b1;
    #1;
    chk_idle("reset");

    // Single word, ready_i held high; also rebuilds the word as a
    // shift_register would (first chunk into the low byte).
    data_i  = 32'hDDCCBBAA;
    valid_i = 1'b1;
    #1;
    chk("single_ready_idle", {31'd0, ready_o}, 32'd1);
    step();
    valid_i = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk_beat("single", 32'hDDCCBBAA, k, (k == 3));
      recv[k * 8 +: 8] = data_o;
      step();
    end
    chk_idle("single_end");
`ifdef CHUNK_SERIALIZER_MSB_FIRST_EN
    chk("loopback", recv, 32'hAABBCCDD);
`else
    chk("loopback", recv, 32'hDDCCBBAA);
`endif

    // Backpressure for 3 cycles while the second chunk is shown.
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    #1;
    chk_beat("bp0", 32'hDDCCBBAA, 0, 1'b0);
    step();
    ready_i = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk_beat("bp_hold", 32'hDDCCBBAA, 1, 1'b0);
      step();
    end
    chk_beat("bp_hold_end", 32'hDDCCBBAA, 1, 1'b0);
    ready_i = 1'b1;
    #1;
    chk_beat("bp1", 32'hDDCCBBAA, 1, 1'b0);
    step();
    chk_beat("bp2", 32'hDDCCBBAA, 2, 1'b0);
    step();
    chk_beat("bp3", 32'hDDCCBBAA, 3, 1'b1);
    step();
    chk_idle("bp_end");

    // Back-to-back words; data_i changes while busy must be ignored.
    data_i  = 32'h44332211;
    valid_i = 1'b1;
    step();
    data_i  = 32'h88776655;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk_beat("b2b_a", 32'h44332211, k, (k == 3));
      step();
    end
    valid_i = 1'b0;
    data_i  = 32'hFFFFFFFF;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk_beat("b2b_b", 32'h88776655, k, (k == 3));
      step();
    end
    chk_idle("b2b_end");

    // Reset on the edge that accepts the third chunk: the fourth never shows.
    data_i  = 32'hDDCCBBAA;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    #1;
    chk_beat("mid0", 32'hDDCCBBAA, 0, 1'b0);
    step();
    chk_beat("mid1", 32'hDDCCBBAA, 1, 1'b0);
    step();
    chk_beat("mid2", 32'hDDCCBBAA, 2, 1'b0);
    rst_n   = 1'b0;
    valid_i = 1'b1;
    step();
    chk_idle("mid_rst");
    rst_n   = 1'b1;
    valid_i = 1'b0;
    #1;
    chk_idle("mid_rel");
    step();
    chk_idle("mid_stay");

    // Next word after the abandoned one starts from chunk 0.
    data_i  = 32'h04030201;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk_beat("after_rst", 32'h04030201, k, (k == 3));
      step();
    end
    chk_idle("after_rst_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
